twisted_ring_counter: RTL

- Parametrised successor to the fixed 4-bit Johnson counter.
- Runtime-selectable Johnson (twisted-ring) or one-hot ring mode, with up/down stepping, count enable, parallel load with legality check, decoded sequence index and wrap pulse.
- Intended as the shared sequencer/phase generator for multi-phase enables and timing strobes.

---
 rtl/twisted_ring_counter.sv | 103 ++++++++++
 1 files changed

// File: rtl/twisted_ring_counter.sv
// Parametrised Johnson / one-hot ring sequencer with up/down stepping,
// checked parallel load, decoded sequence index and wrap/error pulses.
module twisted_ring_counter #(
    parameter  int WIDTH = 4,
    localparam int IW    = $clog2(2 * WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    input  logic             mode,
    input  logic             ld,
    input  logic [WIDTH-1:0] ld_val,
    output logic [WIDTH-1:0] q,
    output logic [IW-1:0]    idx,
    output logic             wrap,
    output logic             err
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic             mode_q, mode_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             wrap_q, wrap_d;
    logic             err_q, err_d;
    logic [IW-1:0]    idx_c, last_c, pc_c, pos_c;

    function automatic logic [WIDTH-1:0] init_of(input logic m);
        return m ? ONE : '0;
    endfunction

    // Johnson legal values have contiguous ones anchored at bit 0 or at the MSB.
    function automatic logic legal(input logic m, input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] nv;
        nv = ~v;
        if (m)
            return (v != '0) && ((v & (v - ONE)) == '0);
        return ((v & (v + ONE)) == '0) || ((nv & (nv + ONE)) == '0);
    endfunction

    always_comb begin
        pc_c  = '0;
        pos_c = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pc_c = pc_c + IW'(q_q[i]);
            if (q_q[i])
                pos_c = IW'(i);
        end
        if (mode_q)
            idx_c = pos_c;
        else if (q_q[0] || (q_q == '0))
            idx_c = pc_c;
        else
            idx_c = IW'(2 * WIDTH) - pc_c;
        last_c = mode_q ? IW'(WIDTH - 1) : IW'(2 * WIDTH - 1);
    end

    always_comb begin
        mode_d = mode_q;
        q_d    = q_q;
        wrap_d = 1'b0;
        err_d  = 1'b0;
        if (mode != mode_q) begin
            mode_d = mode;
            q_d    = init_of(mode);
        end else if (ld) begin
            if (legal(mode_q, ld_val)) begin
                q_d = ld_val;
            end else begin
                q_d   = init_of(mode_q);
                err_d = 1'b1;
            end
        end else if (en) begin
            if (dir) begin
                q_d    = {q_q[WIDTH-2:0], q_q[WIDTH-1] ^ ~mode_q};
                wrap_d = (idx_c == last_c);
            end else begin
                q_d    = {q_q[0] ^ ~mode_q, q_q[WIDTH-1:1]};
                wrap_d = (idx_c == '0);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            mode_q <= mode;
            q_q    <= init_of(mode);
            wrap_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            mode_q <= mode_d;
            q_q    <= q_d;
            wrap_q <= wrap_d;
            err_q  <= err_d;
        end
    end

    assign q    = q_q;
    assign idx  = idx_c;
    assign wrap = wrap_q;
    assign err  = err_q;

endmodule
